// File: rtl/pd_window_pkg.sv
// Shared encodings for the ADPLL phase-error window controller and its up/down counter.
// Holds the count-instruction codes, controller state encoding and the symmetric count limits.
package pd_window_pkg;

    typedef enum logic [1:0] {
        DISABLE    = 2'b00,
        COUNT_UP   = 2'b01,
        COUNT_DOWN = 2'b10
    } count_instr_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_COUNT  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_HOLD   = 3'd4
    } state_e;

    function automatic longint maxval(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    // Symmetric minimum: the most negative two's-complement code is never produced.
    function automatic longint minval(input int width);
        return -maxval(width);
    endfunction

endpackage

// File: rtl/pd_window_timer.sv
// Loadable down-counter that times the COUNT phase of a measurement window.
// last_o flags the final cycle (count == 1); the count stops at zero.
module pd_window_timer #(
    parameter int WIN_W = 16
) (
    input  logic             fpga_clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [WIN_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             last_o
);

    logic [WIN_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - WIN_W'(1);
        end
    end

    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last_o = (count_q == WIN_W'(1));

endmodule

// File: rtl/pd_window_controller.sv
// Runs fixed-length phase-error measurement windows and hands each signed count to the loop filter.
// Optional macro PD_WINDOW_SAT_ABORT_EN: end a window early when the counter saturates, adds early_o.
module pd_window_controller
    import pd_window_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter int WIN_W = 16
) (
    input  logic                    fpga_clk_i,
    input  logic                    reset_i,
    input  logic                    enable_i,
    input  logic [WIN_W-1:0]        window_len_i,
    input  logic                    phase_lead_i,
    input  logic                    phase_lag_i,
    input  logic signed [WIDTH-1:0] counter_val_i,
    output logic [1:0]              count_instr_o,
    output logic                    clear_o,
    output logic signed [WIDTH-1:0] sample_o,
    output logic                    sample_valid_o,
    input  logic                    sample_ready_i,
    output logic                    sat_o,
    output logic                    busy_o
`ifdef PD_WINDOW_SAT_ABORT_EN
    ,
    output logic                    early_o
`endif
);

    localparam logic signed [WIDTH-1:0] MAXVAL = WIDTH'(maxval(WIDTH));
    localparam logic signed [WIDTH-1:0] MINVAL = WIDTH'(minval(WIDTH));

    state_e                  state_q, state_d;
    logic signed [WIDTH-1:0] sample_q, sample_d;
    logic                    sat_q, sat_d;
    count_instr_e            instr, flag_instr;
    logic                    clear;
    logic                    timer_load, timer_dec, timer_last;
    logic [WIN_W-1:0]        len_eff;
    logic                    at_limit;
`ifdef PD_WINDOW_SAT_ABORT_EN
    logic                    early_pend_q, early_pend_d;
    logic                    early_q, early_d;
`endif

    always_comb begin
        flag_instr = DISABLE;
        if (phase_lead_i && !phase_lag_i) begin
            flag_instr = COUNT_UP;
        end else if (phase_lag_i && !phase_lead_i) begin
            flag_instr = COUNT_DOWN;
        end
    end

    assign len_eff  = (window_len_i == '0) ? WIN_W'(1) : window_len_i;
    assign at_limit = (counter_val_i == MAXVAL) || (counter_val_i == MINVAL);

    pd_window_timer #(
        .WIN_W (WIN_W)
    ) u_timer (
        .fpga_clk_i (fpga_clk_i),
        .reset_i    (reset_i),
        .load_i     (timer_load),
        .load_val_i (len_eff),
        .dec_i      (timer_dec),
        .last_o     (timer_last)
    );

    always_comb begin
        state_d    = state_q;
        sample_d   = sample_q;
        sat_d      = sat_q;
        instr      = DISABLE;
        clear      = 1'b0;
        timer_load = 1'b0;
        timer_dec  = 1'b0;
`ifdef PD_WINDOW_SAT_ABORT_EN
        early_pend_d = early_pend_q;
        early_d      = early_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (enable_i) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                clear      = 1'b1;
                timer_load = 1'b1;
                state_d    = ST_COUNT;
`ifdef PD_WINDOW_SAT_ABORT_EN
                early_pend_d = 1'b0;
`endif
            end
            ST_COUNT: begin
                timer_dec = 1'b1;
                // A dropped enable issues no further count so the counter keeps its value until the next CLEAR.
                if (!enable_i) begin
                    state_d = ST_IDLE;
                end else begin
                    instr = flag_instr;
                    if (timer_last) begin
                        state_d = ST_SETTLE;
`ifdef PD_WINDOW_SAT_ABORT_EN
                    end else if (at_limit) begin
                        state_d      = ST_SETTLE;
                        early_pend_d = 1'b1;
`endif
                    end
                end
            end
            ST_SETTLE: begin
                sample_d = counter_val_i;
                sat_d    = at_limit;
                state_d  = ST_HOLD;
`ifdef PD_WINDOW_SAT_ABORT_EN
                early_d  = early_pend_q;
`endif
            end
            ST_HOLD: begin
                if (sample_ready_i) begin
                    state_d = enable_i ? ST_CLEAR : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            sample_q <= '0;
            sat_q    <= 1'b0;
`ifdef PD_WINDOW_SAT_ABORT_EN
            early_pend_q <= 1'b0;
            early_q      <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
            sat_q    <= sat_d;
`ifdef PD_WINDOW_SAT_ABORT_EN
            early_pend_q <= early_pend_d;
            early_q      <= early_d;
`endif
        end
    end

    assign count_instr_o  = instr;
    assign clear_o        = clear;
    assign sample_o       = sample_q;
    assign sat_o          = sat_q;
    assign sample_valid_o = (state_q == ST_HOLD);
    assign busy_o         = (state_q != ST_IDLE);
`ifdef PD_WINDOW_SAT_ABORT_EN
    assign early_o        = early_q;
`endif

endmodule

// File: tb/tb_pd_window_controller.sv
// Self-checking bench for pd_window_controller: a WIDTH=20 and a WIDTH=4 instance, each with a saturating counter model.
// Expected samples are computed from the driven lead/lag patterns and pushed to a scoreboard queue.
module tb_pd_window_controller;

    typedef struct {
        int sample;
        bit sat;
        bit early;
    } exp_t;

    localparam logic signed [19:0] MAX20 = 20'sd524287;
    localparam logic signed [3:0]  MAX4  = 4'sd7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        en_m = 1'b0;
    logic        en4 = 1'b0;
    logic        lead = 1'b0;
    logic        lag = 1'b0;
    logic        ready = 1'b0;
    logic [15:0] wlen = 16'd0;
    logic        sel = 1'b0;

    logic signed [19:0] cnt_m, sample_m;
    logic [1:0]         instr_m;
    logic               clear_m, valid_m, sat_m, busy_m;
    logic signed [3:0]  cnt4, sample4;
    logic [1:0]         instr4;
    logic               clear4, valid4, sat4, busy4;
`ifdef PD_WINDOW_SAT_ABORT_EN
    logic               early_m, early4;
`endif

    pd_window_controller #(.WIDTH(20), .WIN_W(16)) u_dut (
        .fpga_clk_i     (clk),
        .reset_i        (rst),
        .enable_i       (en_m),
        .window_len_i   (wlen),
        .phase_lead_i   (lead),
        .phase_lag_i    (lag),
        .counter_val_i  (cnt_m),
        .count_instr_o  (instr_m),
        .clear_o        (clear_m),
        .sample_o       (sample_m),
        .sample_valid_o (valid_m),
        .sample_ready_i (ready),
        .sat_o          (sat_m),
        .busy_o         (busy_m)
`ifdef PD_WINDOW_SAT_ABORT_EN
        ,
        .early_o        (early_m)
`endif
    );

    pd_window_controller #(.WIDTH(4), .WIN_W(16)) u_dut4 (
        .fpga_clk_i     (clk),
        .reset_i        (rst),
        .enable_i       (en4),
        .window_len_i   (wlen),
        .phase_lead_i   (lead),
        .phase_lag_i    (lag),
        .counter_val_i  (cnt4),
        .count_instr_o  (instr4),
        .clear_o        (clear4),
        .sample_o       (sample4),
        .sample_valid_o (valid4),
        .sample_ready_i (ready),
        .sat_o          (sat4),
        .busy_o         (busy4)
`ifdef PD_WINDOW_SAT_ABORT_EN
        ,
        .early_o        (early4)
`endif
    );

    // Saturating up/down counter models standing in for the real counter instances.
    always_ff @(posedge clk) begin
        if (rst || clear_m) cnt_m <= '0;
        else if (instr_m == 2'b01 && cnt_m != MAX20) cnt_m <= cnt_m + 20'sd1;
        else if (instr_m == 2'b10 && cnt_m != -MAX20) cnt_m <= cnt_m - 20'sd1;
    end

    always_ff @(posedge clk) begin
        if (rst || clear4) cnt4 <= '0;
        else if (instr4 == 2'b01 && cnt4 != MAX4) cnt4 <= cnt4 + 4'sd1;
        else if (instr4 == 2'b10 && cnt4 != -MAX4) cnt4 <= cnt4 - 4'sd1;
    end

    logic [1:0]         obs_instr;
    logic               obs_clear, obs_valid, obs_sat, obs_busy;
    logic signed [19:0] obs_sample;
    assign obs_instr  = sel ? instr4 : instr_m;
    assign obs_clear  = sel ? clear4 : clear_m;
    assign obs_valid  = sel ? valid4 : valid_m;
    assign obs_sat    = sel ? sat4 : sat_m;
    assign obs_busy   = sel ? busy4 : busy_m;
    assign obs_sample = sel ? {{16{sample4[3]}}, sample4} : sample_m;
`ifdef PD_WINDOW_SAT_ABORT_EN
    logic obs_early;
    assign obs_early = sel ? early4 : early_m;
`endif

    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    exp_t last_exp;

    task automatic set_en(input logic v);
        if (sel) en4 = v;
        else en_m = v;
    endtask

    task automatic wait_clear(input string name);
        bit seen = 0;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk); #1;
            if (obs_clear === 1'b1) seen = 1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s clear: clear_o stayed %b for 6 cycles, need 1", name, obs_clear);
        end else begin
            total++;
            if (obs_instr !== 2'b00 || obs_busy !== 1'b1) begin
                bad++;
                $display("FAIL %s clear_state: instr=%b busy=%b, need instr=00 busy=1", name, obs_instr, obs_busy);
            end
        end
    endtask

    // Drives one window from the CLEAR cycle through to the first HOLD cycle and checks the sample.
    task automatic drive_window(input string name, input int len, input logic [31:0] lead_p, input logic [31:0] lag_p);
        int         acc = 0;
        int         lim;
        bit         early = 0;
        logic [1:0] exp_instr;
        exp_t       e;
        lim = sel ? 7 : 524287;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            lead = lead_p[i];
            lag  = lag_p[i];
            #1;
            exp_instr = (lead && !lag) ? 2'b01 : ((lag && !lead) ? 2'b10 : 2'b00);
            total++;
            if (obs_instr !== exp_instr || obs_valid !== 1'b0 || obs_busy !== 1'b1) begin
                bad++;
                $display("FAIL %s count[%0d]: instr=%b valid=%b busy=%b, need instr=%b valid=0 busy=1",
                         name, i, obs_instr, obs_valid, obs_busy, exp_instr);
            end
`ifdef PD_WINDOW_SAT_ABORT_EN
            if ((acc == lim || acc == -lim) && i != len - 1) early = 1;
`endif
            if (exp_instr == 2'b01 && acc != lim) acc++;
            else if (exp_instr == 2'b10 && acc != -lim) acc--;
            if (early) break;
        end
        e.sample = acc;
        e.sat    = (acc == lim || acc == -lim);
        e.early  = early;
        sb.push_back(e);
        @(negedge clk);
        lead = 1'b0;
        lag  = 1'b0;
        #1;
        total++;
        if (obs_instr !== 2'b00 || obs_valid !== 1'b0 || obs_busy !== 1'b1) begin
            bad++;
            $display("FAIL %s settle: instr=%b valid=%b busy=%b, need instr=00 valid=0 busy=1",
                     name, obs_instr, obs_valid, obs_busy);
        end
        @(negedge clk); #1;
        total++;
        if (obs_valid !== 1'b1 || obs_instr !== 2'b00) begin
            bad++;
            $display("FAIL %s hold: valid=%b instr=%b, need valid=1 instr=00", name, obs_valid, obs_instr);
        end
        e = sb.pop_front();
        last_exp = e;
        total++;
        if (obs_sample !== 20'(e.sample) || obs_sat !== e.sat) begin
            bad++;
            $display("FAIL %s sample: sample=%0d sat=%b, need sample=%0d sat=%b",
                     name, obs_sample, obs_sat, e.sample, e.sat);
        end
`ifdef PD_WINDOW_SAT_ABORT_EN
        total++;
        if (obs_early !== e.early) begin
            bad++;
            $display("FAIL %s early: early=%b, need %b", name, obs_early, e.early);
        end
`endif
        $display("window %s: len=%0d sample=%0d sat=%b", name, len, obs_sample, obs_sat);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (instr_m !== 2'b00 || clear_m !== 1'b0 || sample_m !== 20'sd0 || valid_m !== 1'b0 ||
            sat_m !== 1'b0 || busy_m !== 1'b0) begin
            bad++;
            $display("FAIL reset_main: instr=%b clear=%b sample=%0d valid=%b sat=%b busy=%b, need all zero",
                     instr_m, clear_m, sample_m, valid_m, sat_m, busy_m);
        end
        total++;
        if (instr4 !== 2'b00 || clear4 !== 1'b0 || sample4 !== 4'sd0 || valid4 !== 1'b0 ||
            sat4 !== 1'b0 || busy4 !== 1'b0) begin
            bad++;
            $display("FAIL reset_w4: instr=%b clear=%b sample=%0d valid=%b sat=%b busy=%b, need all zero",
                     instr4, clear4, sample4, valid4, sat4, busy4);
        end
        rst = 1'b0;
        $display("reset: checked both instances");
    endtask

    task automatic test_lead8();
        sel = 1'b0; wlen = 16'd8; ready = 1'b1; lead = 1'b1; lag = 1'b0;
        @(negedge clk);
        set_en(1'b1);
        wait_clear("lead8");
        drive_window("lead8", 8, 32'h0000_00FF, 32'h0);
        wlen = 16'd6;
        @(negedge clk); #1;
        total++;
        if (obs_clear !== 1'b1 || obs_valid !== 1'b0) begin
            bad++;
            $display("FAIL lead8 back_to_back: clear=%b valid=%b, need clear=1 valid=0", obs_clear, obs_valid);
        end
    endtask

    task automatic test_back_to_back();
        drive_window("mixed6", 6, 32'h0000_000B, 32'h0000_0034);
        wlen = 16'd2;
        @(negedge clk); #1;
        total++;
        if (obs_clear !== 1'b1 || obs_valid !== 1'b0) begin
            bad++;
            $display("FAIL mixed6 back_to_back: clear=%b valid=%b, need clear=1 valid=0", obs_clear, obs_valid);
        end
        drive_window("both_high", 2, 32'h0000_0003, 32'h0000_0001);
        set_en(1'b0);
        @(negedge clk); #1;
        total++;
        if (obs_busy !== 1'b0 || obs_valid !== 1'b0) begin
            bad++;
            $display("FAIL both_high idle: busy=%b valid=%b, need busy=0 valid=0", obs_busy, obs_valid);
        end
    endtask

    task automatic test_sat4();
        sel = 1'b1; wlen = 16'd20; ready = 1'b1; lead = 1'b0; lag = 1'b1;
        @(negedge clk);
        set_en(1'b1);
        wait_clear("sat4");
        drive_window("sat4", 20, 32'h0, 32'h000F_FFFF);
        set_en(1'b0);
        @(negedge clk); #1;
        total++;
        if (obs_busy !== 1'b0 || obs_valid !== 1'b0) begin
            bad++;
            $display("FAIL sat4 idle: busy=%b valid=%b, need busy=0 valid=0", obs_busy, obs_valid);
        end
        sel = 1'b0;
    endtask

    task automatic test_hold_stall();
        sel = 1'b0; wlen = 16'd4; ready = 1'b0;
        @(negedge clk);
        set_en(1'b1);
        wait_clear("stall");
        drive_window("stall", 4, 32'h0000_000D, 32'h0000_0002);
        set_en(1'b0);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk); #1;
            total++;
            if (obs_valid !== 1'b1 || obs_busy !== 1'b1 || obs_sample !== 20'(last_exp.sample) ||
                obs_sat !== last_exp.sat) begin
                bad++;
                $display("FAIL stall hold[%0d]: valid=%b busy=%b sample=%0d sat=%b, need valid=1 busy=1 sample=%0d sat=%b",
                         i, obs_valid, obs_busy, obs_sample, obs_sat, last_exp.sample, last_exp.sat);
            end
        end
        ready = 1'b1;
        @(negedge clk); #1;
        total++;
        if (obs_valid !== 1'b0 || obs_busy !== 1'b0 || obs_sample !== 20'(last_exp.sample)) begin
            bad++;
            $display("FAIL stall accept: valid=%b busy=%b sample=%0d, need valid=0 busy=0 sample=%0d",
                     obs_valid, obs_busy, obs_sample, last_exp.sample);
        end
    endtask

    task automatic test_abort();
        sel = 1'b0; wlen = 16'd8; ready = 1'b1; lead = 1'b1; lag = 1'b0;
        @(negedge clk);
        set_en(1'b1);
        wait_clear("abort");
        repeat (2) @(negedge clk);
        @(negedge clk);
        set_en(1'b0);
        @(negedge clk); #1;
        total++;
        if (obs_busy !== 1'b0 || obs_valid !== 1'b0 || obs_instr !== 2'b00 || obs_clear !== 1'b0) begin
            bad++;
            $display("FAIL abort idle: busy=%b valid=%b instr=%b clear=%b, need all zero",
                     obs_busy, obs_valid, obs_instr, obs_clear);
        end
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (obs_valid !== 1'b0 || obs_busy !== 1'b0) begin
            bad++;
            $display("FAIL abort no_sample: valid=%b busy=%b, need valid=0 busy=0", obs_valid, obs_busy);
        end
        wlen = 16'd3; lead = 1'b0; lag = 1'b1;
        set_en(1'b1);
        wait_clear("rearm");
        drive_window("rearm", 3, 32'h0, 32'h0000_0007);
        set_en(1'b0);
        @(negedge clk);
    endtask

    task automatic test_reset_hold();
        sel = 1'b0; wlen = 16'd2; ready = 1'b0; lead = 1'b1; lag = 1'b0;
        @(negedge clk);
        set_en(1'b1);
        wait_clear("rst_hold");
        drive_window("rst_hold", 2, 32'h0000_0003, 32'h0);
        rst = 1'b1;
        @(negedge clk); #1;
        total++;
        if (instr_m !== 2'b00 || clear_m !== 1'b0 || sample_m !== 20'sd0 || valid_m !== 1'b0 ||
            sat_m !== 1'b0 || busy_m !== 1'b0) begin
            bad++;
            $display("FAIL rst_hold reset: instr=%b clear=%b sample=%0d valid=%b sat=%b busy=%b, need all zero",
                     instr_m, clear_m, sample_m, valid_m, sat_m, busy_m);
        end
        rst = 1'b0; wlen = 16'd0; ready = 1'b1; lead = 1'b1;
        wait_clear("len0");
        drive_window("len0", 1, 32'h0000_0001, 32'h0);
        set_en(1'b0);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_lead8();
        test_back_to_back();
        test_sat4();
        test_hold_stall();
        test_abort();
        test_reset_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
